branch_resolve_unit: RTL
========================

# branch_resolve_unit

Consumer of the ALU flag vector in the execute stage of the pipelined RV32I core. Registers the flags and branch metadata of the instruction leaving EX, evaluates the RISC-V branch condition from zero/neg/carry/overflow, and drives a one-cycle PC redirect followed by a counted front-end flush. Also keeps a saturating taken-branch performance counter.

## Interface
- FLUSH_CYCLES, 2: cycles flush_o stays high per redirect, including the redirect cycle; legal range 1-15.
- XLEN, 32: width of PC and target.

- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  EX holds a valid instruction this cycle.
- ex_branch_i  in  1  instruction is a conditional branch (B-type).
- ex_jump_i  in  1  instruction is JAL/JALR; unconditionally taken.
- ex_funct3_i  in  3  branch funct3.
- alu_flags_i  in  4  [0] zero, [1] neg, [2] carry, [3] overflow, from the ALU computing a-b for branches.
- ex_target_i  in  XLEN  resolved branch/jump target.
- stall_i  in  1  pipeline stall; no sampling, FSM frozen.
- redirect_valid_o  out  1  one-cycle pulse: fetch must load redirect_pc_o.
- redirect_pc_o  out  XLEN  target; held until next redirect.
- flush_o  out  1  kill IF/ID and ID/EX contents.
- illegal_branch_o  out  1  one-cycle pulse: ex_branch_i with funct3 010/011.
- taken_count_o  out  32  saturating count of redirects.

## Operation
- Flag convention: after subtract, carry = borrow, i.e. carry=1 iff a < b unsigned.
- Conditions: 000 BEQ zero; 001 BNE !zero; 100 BLT neg^overflow; 101 BGE !(neg^overflow); 110 BLTU carry; 111 BGEU !carry; 010/011 never taken, raise illegal_branch_o.
- take = ex_valid_i & !stall_i & state==IDLE & (ex_jump_i | (ex_branch_i & cond)). ex_jump_i has priority over ex_branch_i.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE: on take -> REDIRECT, latch ex_target_i into redirect_pc_o, load flush counter with FLUSH_CYCLES-1.
  - REDIRECT: redirect_valid_o=1, flush_o=1 for exactly one cycle; -> FLUSH if counter>0, else IDLE.
  - FLUSH: flush_o=1, counter decrements; -> IDLE when counter reaches 0 at end of cycle. ex_valid_i ignored (instruction is wrong-path).
- Non-taken or illegal branches: no state change, no flush.
- taken_count_o increments once per REDIRECT entry; holds at 0xFFFF_FFFF.

## Timing
- Reset (async assert, sync-to-clock deassert assumed external): state IDLE, redirect_valid_o=0, flush_o=0, illegal_branch_o=0, redirect_pc_o=0, taken_count_o=0, counter=0. Reset mid-REDIRECT/FLUSH aborts immediately; outputs drop asynchronously.
- Latency: inputs sampled at edge N; redirect_valid_o and flush_o high in cycle N+1; illegal_branch_o high in cycle N+1 only.
- stall_i high: no sampling in IDLE; in REDIRECT/FLUSH, state, counter and all outputs hold (redirect_valid_o may thus stay high more than one cycle, fetch consumes it when unstalled).
- Branch in EX while in REDIRECT/FLUSH: discarded, never counted, never flagged illegal.
- Back-to-back: a taken branch sampled on the edge that returns FLUSH->IDLE is ignored; earliest next sample is the following edge.
- FLUSH_CYCLES=1: REDIRECT -> IDLE directly; flush_o high one cycle.

## Test plan
- BLTU: funct3=110, a=0xA000_0000, b=0xC000_0000 (carry=1), target 0x100 -> redirect_valid_o pulse next cycle, redirect_pc_o=0x100, flush_o high 2 cycles, taken_count_o=1; repeat with b=0x4000_0000 (carry=0) -> no redirect.
- BLT vs BGE: flags neg=1,overflow=1 (0x4000_0000+0x4000_0000 style overflow) -> BLT not taken, BGE taken; neg=1,overflow=0 -> BLT taken.
- BEQ/BNE with zero=1 -> BEQ taken, BNE not; JAL with flags=0 -> taken, target latched.
- Illegal funct3=010 with ex_branch_i=1 -> illegal_branch_o one-cycle pulse, no flush, count unchanged.
- Redirect then stall_i=1 for 3 cycles during FLUSH -> flush_o held, counter frozen, branch presented during stall ignored; release -> IDLE after remaining flush cycle.
- rst_n low in REDIRECT -> all outputs 0 immediately, taken_count_o=0; force count to 0xFFFF_FFFF then take -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump outcome for the instruction leaving EX and sequences
// a one-cycle PC redirect followed by a counted front-end flush.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic            ex_branch_i,
    input  logic            ex_jump_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [3:0]      alu_flags_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            stall_i,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            illegal_branch_o,
    output logic [31:0]     taken_count_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_flush_cnt;
    logic              r_redirect_valid;
    logic              r_flush;
    logic              r_illegal;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [31:0]       r_taken_count;

    logic w_zero;
    logic w_neg;
    logic w_carry;
    logic w_ovf;
    logic w_cond;
    logic w_f3_illegal;
    logic w_sample;
    logic w_take;
    logic w_illegal;

    assign w_zero  = alu_flags_i[0];
    assign w_neg   = alu_flags_i[1];
    assign w_carry = alu_flags_i[2];
    assign w_ovf   = alu_flags_i[3];

    // Carry is the borrow of a-b, so it directly means a < b unsigned.
    always_comb begin
        w_cond       = 1'b0;
        w_f3_illegal = 1'b0;
        case (ex_funct3_i)
            3'b000:         w_cond = w_zero;
            3'b001:         w_cond = ~w_zero;
            3'b100:         w_cond = w_neg ^ w_ovf;
            3'b101:         w_cond = ~(w_neg ^ w_ovf);
            3'b110:         w_cond = w_carry;
            3'b111:         w_cond = ~w_carry;
            3'b010, 3'b011: w_f3_illegal = 1'b1;
            default:        w_cond = 1'b0;
        endcase
    end

    assign w_sample  = ex_valid_i & ~stall_i & (r_state == IDLE);
    assign w_take    = w_sample & (ex_jump_i | (ex_branch_i & w_cond));
    assign w_illegal = w_sample & ~ex_jump_i & ex_branch_i & w_f3_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_flush_cnt      <= 4'd0;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_illegal        <= 1'b0;
            r_redirect_pc    <= '0;
            r_taken_count    <= 32'd0;
        end else begin
            r_illegal <= w_illegal;
            if (!stall_i) begin
                case (r_state)
                    IDLE: begin
                        if (w_take) begin
                            r_state          <= REDIRECT;
                            r_redirect_valid <= 1'b1;
                            r_flush          <= 1'b1;
                            r_redirect_pc    <= ex_target_i;
                            r_flush_cnt      <= FLUSH_LOAD;
                            if (r_taken_count != 32'hFFFF_FFFF)
                                r_taken_count <= r_taken_count + 32'd1;
                        end
                    end
                    REDIRECT: begin
                        r_redirect_valid <= 1'b0;
                        if (r_flush_cnt != 4'd0) begin
                            r_state <= FLUSH;
                        end else begin
                            r_state <= IDLE;
                            r_flush <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                        if (r_flush_cnt <= 4'd1) begin
                            r_state     <= IDLE;
                            r_flush     <= 1'b0;
                            r_flush_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                        r_flush          <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign flush_o          = r_flush;
    assign illegal_branch_o = r_illegal;
    assign taken_count_o    = r_taken_count;

endmodule
